id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the 5-stage RISC-V core. Captures decoded control, operands, immediate and instruction fields from ID. Presents them to EX one cycle later: ALUOp/func3/func7_5 feed alu_control, operands feed the ALU and forwarding muxes. Supports hazard-unit stall (hold) and flush (bubble insertion) with a per-stage valid bit.

Parameters:
XLEN, 64, datapath width of PC, register operands and immediate
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold all EX-side outputs this cycle (from hazard unit)
flush  input  1  load a bubble this cycle (load-use or branch-taken)
id_valid  input  1  ID slot holds a real instruction
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src  input  1 each  decoded control bits
id_alu_op  input  2  ALUOp (00 ld/sd, 01 beq, 10 R-type)
id_pc  input  XLEN  instruction PC
id_rd1, id_rd2  input  XLEN  register file read data
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register indices
id_func3  input  3  instr[14:12]
id_func7_5  input  1  instr[30]
ex_valid  output  1  EX slot holds a real instruction
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src  output  1 each  registered control
ex_alu_op  output  2  registered ALUOp
ex_pc, ex_rd1, ex_rd2, ex_imm  output  XLEN  registered data
ex_rs1, ex_rs2, ex_rd  output  REG_ADDR_W  registered indices
ex_func3  output  3  registered func3
ex_func7_5  output  1  registered func7_5

Behaviour:
- All outputs registered; nothing combinational from inputs to outputs. Latency exactly 1 cycle on a load.
- Per-edge priority: rst > flush > stall > load.
- rst=1: every output 0 (ex_valid=0, all control 0, ex_alu_op=00, data/indices/func fields 0).
- flush=1 (rst=0): bubble. ex_valid, all six control bits and ex_alu_op forced 0. All data, index and func fields forced 0. Bubble must never write the register file or memory, assert branch or assert mem_read.
- flush=1 with stall=1: flush wins; bubble loaded.
- stall=1 (rst=0, flush=0): every output holds its previous value, including ex_valid. Held for any number of consecutive cycles.
- Normal load (rst=0, flush=0, stall=0): every ex_* output takes the matching id_* input.
- Normal load with id_valid=0: ex_valid=0 and all control bits forced 0, same as a bubble. Data fields are loaded as presented.
- ex_alu_op is passed unchanged. Bubbles yield 00, so alu_control decodes ADD; this is harmless because all write and mem controls are 0.
- rst asserted mid-stall or mid-flush: reset values next edge. First load after rst deasserts behaves normally.
- No internal state other than the output registers.

Test Plan:
- Reset: drive all id_* nonzero, rst=1 for 2 cycles -> all ex_* = 0, ex_valid=0. rst=0, id_valid=1, id_pc=0x40 -> next edge ex_pc=0x40, ex_valid=1.
- Pass-through: R-type SUB (id_alu_op=10, func3=000, func7_5=1, rd1=7, rd2=3, rd=5, reg_write=1) -> one edge later matching ex_* values. alu_control downstream yields 0110.
- Stall hold: load ld (alu_op=00, mem_read=1, imm=0x10). Then stall=1 for 3 cycles while id_* change to sd values -> ex_* stay the ld values for all 3 cycles. Release -> sd values on next edge.
- Flush: ex holds beq (branch=1, alu_op=01). Assert flush=1 and stall=1 together -> next edge ex_valid=0, all control 0, ex_alu_op=00, ex_rd=0.
- Invalid ID slot: id_valid=0, id_reg_write=1, id_mem_write=1, id_rd=9 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Reset during stall: stall=1 holding valid instruction, rst=1 one cycle -> all outputs 0 next edge. Then stall=0 with new instruction -> loads normally.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: holds decoded control, operands and
// instruction fields for EX, with stall (hold) and flush (bubble).
module id_ex_pipe_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_alu_src,
  input  logic [1:0]            id_alu_op,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_func3,
  input  logic                  id_func7_5,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rd1,
  output logic [XLEN-1:0]       ex_rd2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_func3,
  output logic                  ex_func7_5
);

  // An invalid ID slot is loaded with all control squashed,
  // so it behaves exactly like a bubble downstream.
  logic v;
  assign v = id_valid;

  // Reset/flush load a bubble, stall holds, otherwise load from ID.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_pc         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_func3      <= 3'b000;
      ex_func7_5    <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= v;
      ex_reg_write  <= v & id_reg_write;
      ex_mem_to_reg <= v & id_mem_to_reg;
      ex_mem_read   <= v & id_mem_read;
      ex_mem_write  <= v & id_mem_write;
      ex_branch     <= v & id_branch;
      ex_alu_src    <= v & id_alu_src;
      ex_alu_op     <= v ? id_alu_op : 2'b00;
      ex_pc         <= id_pc;
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_func3      <= id_func3;
      ex_func7_5    <= id_func7_5;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table plus
// randomized cycles against a slot-level reference model.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [2:0]      func3;
    logic            func7_5;
  } slot_t;

  typedef struct {
    string name;
    logic  rst;
    logic  flush;
    logic  stall;
    slot_t in;
    slot_t exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst, stall, flush;
  slot_t id_b, ex_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_b.valid),
    .id_reg_write  (id_b.reg_write),
    .id_mem_to_reg (id_b.mem_to_reg),
    .id_mem_read   (id_b.mem_read),
    .id_mem_write  (id_b.mem_write),
    .id_branch     (id_b.branch),
    .id_alu_src    (id_b.alu_src),
    .id_alu_op     (id_b.alu_op),
    .id_pc         (id_b.pc),
    .id_rd1        (id_b.rd1),
    .id_rd2        (id_b.rd2),
    .id_imm        (id_b.imm),
    .id_rs1        (id_b.rs1),
    .id_rs2        (id_b.rs2),
    .id_rd         (id_b.rd),
    .id_func3      (id_b.func3),
    .id_func7_5    (id_b.func7_5),
    .ex_valid      (ex_b.valid),
    .ex_reg_write  (ex_b.reg_write),
    .ex_mem_to_reg (ex_b.mem_to_reg),
    .ex_mem_read   (ex_b.mem_read),
    .ex_mem_write  (ex_b.mem_write),
    .ex_branch     (ex_b.branch),
    .ex_alu_src    (ex_b.alu_src),
    .ex_alu_op     (ex_b.alu_op),
    .ex_pc         (ex_b.pc),
    .ex_rd1        (ex_b.rd1),
    .ex_rd2        (ex_b.rd2),
    .ex_imm        (ex_b.imm),
    .ex_rs1        (ex_b.rs1),
    .ex_rs2        (ex_b.rs2),
    .ex_rd         (ex_b.rd),
    .ex_func3      (ex_b.func3),
    .ex_func7_5    (ex_b.func7_5)
  );

  function automatic slot_t mk(
    input logic v, rw, mtr, mr, mw, br, as,
    input logic [1:0] op,
    input logic [XLEN-1:0] pc, r1, r2, im,
    input logic [RW-1:0] s1, s2, d,
    input logic [2:0] f3,
    input logic f7
  );
    slot_t s;
    s.valid = v;      s.reg_write = rw;
    s.mem_to_reg = mtr; s.mem_read = mr;
    s.mem_write = mw; s.branch = br;
    s.alu_src = as;   s.alu_op = op;
    s.pc = pc;        s.rd1 = r1;
    s.rd2 = r2;       s.imm = im;
    s.rs1 = s1;       s.rs2 = s2;
    s.rd = d;         s.func3 = f3;
    s.func7_5 = f7;
    return s;
  endfunction

  // What EX must show after one edge, from the slot's rules.
  function automatic slot_t ref_next(
    input slot_t prev, input slot_t in,
    input logic r, input logic f, input logic s
  );
    slot_t n;
    if (r || f) return '0;
    if (s) return prev;
    n = in;
    if (!in.valid) begin
      n.reg_write = 0; n.mem_to_reg = 0;
      n.mem_read = 0;  n.mem_write = 0;
      n.branch = 0;    n.alu_src = 0;
      n.alu_op = 2'b00;
    end
    return n;
  endfunction

  // Downstream ALU control, used to confirm EX decodes SUB.
  function automatic logic [3:0] alu_ctl(
    input logic [1:0] op, input logic f7, input logic [2:0] f3
  );
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'b000:  return f7 ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.valid = 1'($urandom);     s.reg_write = 1'($urandom);
    s.mem_to_reg = 1'($urandom); s.mem_read = 1'($urandom);
    s.mem_write = 1'($urandom); s.branch = 1'($urandom);
    s.alu_src = 1'($urandom);   s.alu_op = 2'($urandom);
    s.pc  = {$urandom, $urandom};
    s.rd1 = {$urandom, $urandom};
    s.rd2 = {$urandom, $urandom};
    s.imm = {$urandom, $urandom};
    s.rs1 = 5'($urandom); s.rs2 = 5'($urandom);
    s.rd  = 5'($urandom); s.func3 = 3'($urandom);
    s.func7_5 = 1'($urandom);
    return s;
  endfunction

  task automatic check(input string nm, input slot_t exp);
    tests++;
    if (ex_b !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, ex_b, exp);
    end
  endtask

  // Drive at negedge, let one rising edge pass, sample at negedge.
  task automatic step(
    input logic r, input logic f, input logic s, input slot_t in
  );
    rst = r; flush = f; stall = s; id_b = in;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t  tbl[$];
  slot_t a, b0, sub_i, ld_i, sd_i, beq_i, inv_i, inv_x, model;

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; id_b = '0;

    a = mk(1,1,1,1,1,1,1,2'b11, 64'hAAAA_5555_AAAA_5555,
      64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
      64'h9999_AAAA_BBBB_CCCC, 5'd31, 5'd30, 5'd29, 3'd7, 1'b1);
    b0 = mk(1,0,0,0,0,0,0,2'b00, 64'h40,
      64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
    sub_i = mk(1,1,0,0,0,0,0,2'b10, 64'h44,
      64'd7, 64'd3, 64'h0, 5'd1, 5'd2, 5'd5, 3'b000, 1'b1);
    ld_i = mk(1,1,1,1,0,0,1,2'b00, 64'h48,
      64'h1000, 64'h0, 64'h10, 5'd3, 5'd0, 5'd6, 3'b011, 1'b0);
    sd_i = mk(1,0,0,0,1,0,1,2'b00, 64'h4c,
      64'h1000, 64'h55, 64'h8, 5'd3, 5'd4, 5'd0, 3'b011, 1'b0);
    beq_i = mk(1,0,0,0,0,1,0,2'b01, 64'h50,
      64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF0,
      5'd5, 5'd5, 5'd8, 3'b000, 1'b0);
    inv_i = mk(0,1,0,0,1,0,0,2'b10, 64'h54,
      64'd1, 64'd2, 64'd3, 5'd1, 5'd2, 5'd9, 3'b001, 1'b1);
    inv_x = mk(0,0,0,0,0,0,0,2'b00, 64'h54,
      64'd1, 64'd2, 64'd3, 5'd1, 5'd2, 5'd9, 3'b001, 1'b1);

    tbl.push_back('{"reset1",     1,0,0, a,     '0});
    tbl.push_back('{"reset2",     1,0,0, a,     '0});
    tbl.push_back('{"first_load", 0,0,0, b0,    b0});
    tbl.push_back('{"sub_pass",   0,0,0, sub_i, sub_i});
    tbl.push_back('{"ld_load",    0,0,0, ld_i,  ld_i});
    tbl.push_back('{"stall1",     0,0,1, sd_i,  ld_i});
    tbl.push_back('{"stall2",     0,0,1, sd_i,  ld_i});
    tbl.push_back('{"stall3",     0,0,1, sd_i,  ld_i});
    tbl.push_back('{"stall_rel",  0,0,0, sd_i,  sd_i});
    tbl.push_back('{"beq_load",   0,0,0, beq_i, beq_i});
    tbl.push_back('{"flush_stl",  0,1,1, a,     '0});
    tbl.push_back('{"invalid_id", 0,0,0, inv_i, inv_x});
    tbl.push_back('{"reload_sub", 0,0,0, sub_i, sub_i});
    tbl.push_back('{"hold_sub",   0,0,1, a,     sub_i});
    tbl.push_back('{"rst_in_stl", 1,0,1, a,     '0});
    tbl.push_back('{"post_rst",   0,0,0, ld_i,  ld_i});
    tbl.push_back('{"rst_flush",  1,1,0, a,     '0});
    tbl.push_back('{"after_rf",   0,0,0, a,     a});

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].in);
      check(tbl[i].name, tbl[i].exp);
      if (tbl[i].name == "sub_pass") begin
        tests++;
        if (alu_ctl(ex_b.alu_op, ex_b.func7_5, ex_b.func3)
            !== 4'b0110) begin
          fails++;
          $display("FAIL sub_aluctl got=%b exp=0110",
            alu_ctl(ex_b.alu_op, ex_b.func7_5, ex_b.func3));
        end
      end
    end

    model = tbl[tbl.size()-1].exp;
    for (int i = 0; i < 500; i++) begin
      logic r, f, s;
      slot_t in;
      r  = ($urandom_range(0, 31) == 0);
      f  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      in = rnd_slot();
      step(r, f, s, in);
      model = ref_next(model, in, r, f, s);
      check("random", model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
